// File: rtl/move_entry.sv
// move_entry
//   Human move entry for a 3x3 board game. Synchronizes the square-select
//   switches and the enter pushbutton, debounces enter, and on each press
//   validates the selected square against the board occupancy (human and
//   computer moves). A valid square is accepted; anything else is rejected.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   sw[3:0]    in   raw square-select switches (squares 0-8)
//   enter      in   raw bouncing pushbutton, high = pressed
//   c_move     in   square taken by the computer player
//   c_valid    in   one-cycle strobe qualifying c_move
//   h_move     out  last accepted human square, 4'hF = none yet
//   move_valid out  one-cycle pulse when h_move updates
//   move_err   out  one-cycle pulse on a rejected press
//   occupied   out  bit i set = square i taken by either player
//   move_count out  accepted human moves, saturating at 9
//   board_full out  all nine squares taken
//
// state        | meaning
// -------------+-----------------------------------------------------
// IDLE         | waiting for a debounced press
// CHECK        | validating the captured square against the board
// ACCEPT       | move_valid pulse, occupancy/count update
// REJECT       | move_err pulse, nothing else changes
// WAIT_RELEASE | holding off until the button is released
module move_entry #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       enter,
  input  logic [3:0] c_move,
  input  logic       c_valid,
  output logic [3:0] h_move,
  output logic       move_valid,
  output logic       move_err,
  output logic [8:0] occupied,
  output logic [3:0] move_count,
  output logic       board_full
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ACCEPT,
    REJECT,
    WAIT_RELEASE
  } state_t;

  state_t      state;
  logic [3:0]  sw_s1, sw_s2;
  logic        en_s1, en_s2;
  logic        db_level, db_prev;
  logic [15:0] db_cnt;
  logic [3:0]  sw_cap;

  logic        press;
  logic [8:0]  c_bits;
  logic [8:0]  cap_bits;
  logic        check_ok;

  // One-hot square decode; squares above 8 decode to nothing.
  function automatic logic [8:0] decode_sq(input logic [3:0] sq);
    logic [8:0] d;
    d = '0;
    for (int i = 0; i < 9; i++) begin
      if (sq == 4'(i)) d[i] = 1'b1;
    end
    return d;
  endfunction

  assign board_full = (occupied == 9'h1FF);

  always_comb begin
    press    = db_level & ~db_prev;
    c_bits   = c_valid ? decode_sq(c_move) : 9'h000;
    cap_bits = decode_sq(sw_cap);
    // A computer move landing in the CHECK cycle counts as already taken.
    check_ok = (sw_cap <= 4'd8) && !board_full &&
               ((cap_bits & (occupied | c_bits)) == 9'h000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sw_s1      <= '0;
      sw_s2      <= '0;
      en_s1      <= 1'b0;
      en_s2      <= 1'b0;
      db_level   <= 1'b0;
      db_prev    <= 1'b0;
      db_cnt     <= '0;
      sw_cap     <= '0;
      h_move     <= 4'hF;
      move_valid <= 1'b0;
      move_err   <= 1'b0;
      occupied   <= '0;
      move_count <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      en_s1 <= enter;
      en_s2 <= en_s1;

      if (en_s2 != db_level) begin
        if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
          db_level <= ~db_level;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
      end else begin
        db_cnt <= '0;
      end
      db_prev <= db_level;

      move_valid <= 1'b0;
      move_err   <= 1'b0;
      occupied   <= occupied | c_bits;

      case (state)
        IDLE: begin
          if (press) begin
            sw_cap <= sw_s2;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (check_ok) begin
            move_valid <= 1'b1;
            h_move     <= sw_cap;
            state      <= ACCEPT;
          end else begin
            move_err <= 1'b1;
            state    <= REJECT;
          end
        end
        ACCEPT: begin
          // OR-merge so a simultaneous computer move on the same square is benign.
          occupied <= occupied | c_bits | cap_bits;
          if (move_count != 4'd9) move_count <= move_count + 4'd1;
          state <= WAIT_RELEASE;
        end
        REJECT: begin
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!db_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_entry.sv
// tb_move_entry
//   Directed bench for move_entry with DEBOUNCE_CYCLES = 4. Inputs are driven
//   and outputs sampled on the falling clock edge. With enter raised at
//   falling edge N0, the debounced level rises at rising edge E6, the FSM is
//   in CHECK between E7 and E8, and the result pulse is visible at N8.
module tb_move_entry;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       enter;
  logic [3:0] c_move;
  logic       c_valid;
  logic [3:0] h_move;
  logic       move_valid;
  logic       move_err;
  logic [8:0] occupied;
  logic [3:0] move_count;
  logic       board_full;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;

  move_entry #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .enter      (enter),
    .c_move     (c_move),
    .c_valid    (c_valid),
    .h_move     (h_move),
    .move_valid (move_valid),
    .move_err   (move_err),
    .occupied   (occupied),
    .move_count (move_count),
    .board_full (board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (move_valid) valid_cnt++;
    if (move_err) err_cnt++;
    if (move_valid && move_err) both_cnt++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Press square s; optionally strobe c_valid/cmv on falling edge cstep
  // (7 = during CHECK, 8 = during ACCEPT/REJECT). Hold, release, settle.
  task automatic do_press(input logic [3:0] s, input bit exp_valid,
                          input logic [3:0] cmv, input int cstep,
                          input logic [3:0] exp_h, input string name);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    sw    = s;
    enter = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      c_valid = (i == cstep);
      c_move  = (i == cstep) ? cmv : 4'd0;
    end
    checks++;
    if (move_valid !== exp_valid || move_err !== !exp_valid) begin
      failures++;
      $display("FAIL %s pulse: valid=%b err=%b required valid=%b err=%b",
               name, move_valid, move_err, exp_valid, !exp_valid);
    end
    checks++;
    if (h_move !== exp_h) begin
      failures++;
      $display("FAIL %s h_move: got %h required %h", name, h_move, exp_h);
    end
    @(negedge clk);
    c_valid = 1'b0;
    idle(10);
    enter = 1'b0;
    idle(15);
    checks++;
    if ((valid_cnt - v0) != int'(exp_valid) || (err_cnt - e0) != int'(!exp_valid)) begin
      failures++;
      $display("FAIL %s pulse_count: valid=%0d err=%0d required valid=%0d err=%0d",
               name, valid_cnt - v0, err_cnt - e0, int'(exp_valid), int'(!exp_valid));
    end
  endtask

  task automatic check_state(input logic [8:0] exp_occ, input logic [3:0] exp_cnt,
                             input string name);
    checks++;
    if (occupied !== exp_occ) begin
      failures++;
      $display("FAIL %s occupied: got %h required %h", name, occupied, exp_occ);
    end
    checks++;
    if (move_count !== exp_cnt) begin
      failures++;
      $display("FAIL %s move_count: got %0d required %0d", name, move_count, exp_cnt);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (h_move !== 4'hF || move_valid !== 1'b0 || move_err !== 1'b0 ||
        occupied !== 9'h000 || move_count !== 4'd0 || board_full !== 1'b0) begin
      failures++;
      $display("FAIL %s: h=%h v=%b e=%b occ=%h cnt=%0d full=%b required h=f v=0 e=0 occ=000 cnt=0 full=0",
               name, h_move, move_valid, move_err, occupied, move_count, board_full);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_basic;
    do_press(4'd1, 1'b1, 4'd0, 0, 4'd1, "basic");
    check_state(9'h002, 4'd1, "basic");
  endtask

  task automatic test_bounce;
    int v0;
    v0 = valid_cnt;
    @(negedge clk);
    sw = 4'd2;
    for (int i = 0; i < 10; i++) begin
      enter = ~enter;
      @(negedge clk);
    end
    enter = 1'b1;
    idle(30);
    enter = 1'b0;
    idle(15);
    checks++;
    if (valid_cnt - v0 != 1) begin
      failures++;
      $display("FAIL bounce pulses: got %0d required 1", valid_cnt - v0);
    end
    checks++;
    if (h_move !== 4'd2) begin
      failures++;
      $display("FAIL bounce h_move: got %h required 2", h_move);
    end
    check_state(9'h006, 4'd2, "bounce");
  endtask

  task automatic test_computer_taken;
    @(negedge clk);
    c_valid = 1'b1;
    c_move  = 4'd4;
    @(negedge clk);
    c_move  = 4'd12;
    @(negedge clk);
    c_valid = 1'b0;
    idle(2);
    check_state(9'h016, 4'd2, "cpu_strobe");
    do_press(4'd4, 1'b0, 4'd0, 0, 4'd2, "cpu_taken");
    check_state(9'h016, 4'd2, "cpu_taken");
  endtask

  task automatic test_out_of_range;
    do_press(4'd9, 1'b0, 4'd0, 0, 4'd2, "sw9");
    check_state(9'h016, 4'd2, "sw9");
    do_press(4'd15, 1'b0, 4'd0, 0, 4'd2, "sw15");
    check_state(9'h016, 4'd2, "sw15");
  endtask

  task automatic test_race_check;
    do_press(4'd6, 1'b0, 4'd6, 7, 4'd2, "race_check");
    check_state(9'h056, 4'd2, "race_check");
  endtask

  task automatic test_race_accept;
    do_press(4'd7, 1'b1, 4'd7, 8, 4'd7, "race_accept");
    check_state(9'h0D6, 4'd3, "race_accept");
  endtask

  task automatic test_reset_in_check;
    int v0, e0;
    bit seen;
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    sw    = 4'd0;
    enter = 1'b1;
    idle(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset_in_check");
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (move_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || h_move !== 4'd0) begin
      failures++;
      $display("FAIL held_through_reset: seen=%b h_move=%h required seen=1 h_move=0",
               seen, h_move);
    end
    enter = 1'b0;
    idle(15);
    checks++;
    if (valid_cnt - v0 != 1 || err_cnt - e0 != 0) begin
      failures++;
      $display("FAIL reset_abort pulses: valid=%0d err=%0d required valid=1 err=0",
               valid_cnt - v0, err_cnt - e0);
    end
    check_state(9'h001, 4'd1, "held_through_reset");
  endtask

  task automatic test_fill;
    for (int s = 1; s <= 7; s++)
      do_press(4'(s), 1'b1, 4'd0, 0, 4'(s), "fill");
    checks++;
    if (board_full !== 1'b0) begin
      failures++;
      $display("FAIL fill early_full: got %b required 0", board_full);
    end
    do_press(4'd8, 1'b1, 4'd0, 0, 4'd8, "fill_last");
    check_state(9'h1FF, 4'd9, "fill_last");
    checks++;
    if (board_full !== 1'b1) begin
      failures++;
      $display("FAIL fill board_full: got %b required 1", board_full);
    end
    do_press(4'd5, 1'b0, 4'd0, 0, 4'd8, "full_press");
    check_state(9'h1FF, 4'd9, "full_press");
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL exclusive: both high %0d cycles required 0", both_cnt);
    end
  endtask

  initial begin
    rst     = 1'b1;
    sw      = 4'd0;
    enter   = 1'b0;
    c_move  = 4'd0;
    c_valid = 1'b0;
    test_reset;
    test_basic;
    test_bounce;
    test_computer_taken;
    test_out_of_range;
    test_race_check;
    test_race_accept;
    test_reset_in_check;
    test_fill;
    test_exclusive;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning consecutive identical synchronized samples needed to accept a new button level (benches use 4).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sw  input  4  raw, asynchronous square-select switches (squares 0-8).
REQ-005 SHALL have port enter  input  1  raw, bouncing, asynchronous pushbutton (high = pressed).
REQ-006 SHALL have port c_move  input  4  square taken by the computer player.
REQ-007 SHALL have port c_valid  input  1  one-cycle strobe marking c_move as taken.
REQ-008 SHALL have port h_move  output  4  last accepted human square; 4'hF = no move yet.
REQ-009 SHALL have port move_valid  output  1  one-cycle pulse when h_move updates.
REQ-010 SHALL have port move_err  output  1  one-cycle pulse on a rejected press.
REQ-011 SHALL have port occupied  output  9  bit i set = square i taken by either player.
REQ-012 SHALL have port move_count  output  4  accepted human moves, 0-9.
REQ-013 SHALL have port board_full  output  1  high when occupied == 9'h1FF.

Function
REQ-014 SHALL pass sw and enter through two-flop synchronizers before any other use.
REQ-015 SHALL debounce synchronized enter: counter increments while sample differs from debounced level, clears when equal; debounced level toggles and counter clears when count reaches DEBOUNCE_CYCLES-1.
REQ-016 SHALL detect a press as a 0->1 transition of the registered debounced level, and capture synchronized sw in that same cycle (cycle k).
REQ-017 SHALL implement states IDLE, CHECK, ACCEPT, REJECT, WAIT_RELEASE.
REQ-018 SHALL transition IDLE->CHECK on press; other inputs ignored in IDLE.
REQ-019 SHALL, in CHECK (cycle k+1), go to ACCEPT when captured sw <= 8, board_full low, and square not in (occupied OR decode of c_move when c_valid is high this cycle); otherwise go to REJECT.
REQ-020 SHALL, in ACCEPT (cycle k+2), assert move_valid for exactly that cycle with h_move already equal to captured sw, set its occupied bit, increment move_count, then go to WAIT_RELEASE.
REQ-021 SHALL, in REJECT (cycle k+2), assert move_err for exactly that cycle, leave h_move, occupied, move_count unchanged, then go to WAIT_RELEASE.
REQ-022 SHALL stay in WAIT_RELEASE until debounced enter is low, then return to IDLE; a held button never produces a second move.
REQ-023 SHALL set occupied[c_move] on any cycle c_valid is high and c_move <= 8, in any state; c_move > 8 ignored; setting an already-set bit is harmless.
REQ-024 SHALL, when c_valid and ACCEPT target the same square in the same cycle, still accept the human move (CHECK already passed) and set the bit once.
REQ-025 SHALL never clear occupied bits except by reset; move_count saturates at 9.
REQ-026 SHALL hold h_move stable between accepted moves (downstream FSM samples it as a level).
REQ-027 SHALL keep move_valid and move_err mutually exclusive.

Reset
REQ-028 SHALL, on rst high at a clock edge, set state IDLE, h_move 4'hF, move_valid 0, move_err 0, occupied 0, move_count 0, debounced level 0, debounce counter 0, synchronizers 0.
REQ-029 SHALL abort any in-progress CHECK/ACCEPT/REJECT on reset with no pulse emitted; a button held through reset is detected as a new press after debounce.

Verification
REQ-030 SHALL cover: DEBOUNCE_CYCLES=4, sw=1, clean enter press -> move_valid one cycle, h_move=1, occupied=9'h002, move_count=1; release, no further pulse.
REQ-031 SHALL cover: enter toggling every cycle for 10 cycles then held high -> exactly one move_valid.
REQ-032 SHALL cover: c_valid with c_move=4, then human press sw=4 -> move_err pulse, h_move unchanged, occupied=9'h010.
REQ-033 SHALL cover: press with sw=9 and sw=15 -> move_err each time, occupied and move_count unchanged.
REQ-034 SHALL cover: c_valid c_move=6 in same cycle as CHECK for sw=6 -> move_err; occupied bit 6 set.
REQ-035 SHALL cover: rst asserted during CHECK -> no pulse, all outputs at reset values next cycle; fill all 9 squares -> board_full=1, further presses yield move_err.
